// File: rtl/mem_block_dp.sv
// ---------------------------------------------------------------------------
// mem_block_dp
// Dual-port synchronous memory. Port A is read/write (data path), port B is
// read-only (instruction fetch). Reads are registered with RD_LAT cycles of
// latency and a valid strobe. After every reset the array is cleared to
// INIT_VAL, one word per cycle, and o_ready rises when that is done.
//
// Ports:
//   i_clock, i_resetn           clock, asynchronous active-low reset
//   o_ready                     clear sequence done, requests accepted
//   i_a_req, i_a_wr_en          port A strobe and write/read select
//   i_a_addr, i_a_data          port A address and write data
//   o_a_q, o_a_valid, o_a_err   port A read data, valid pulse, range error
//   i_b_req, i_b_addr           port B read strobe and address
//   o_b_q, o_b_valid            port B read data and valid pulse
// ---------------------------------------------------------------------------
module mem_block_dp #(
    parameter int unsigned      ADDR_BITS = 5,
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 32,
    parameter int unsigned      RD_LAT    = 1,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
    input  logic                 i_clock,
    input  logic                 i_resetn,
    output logic                 o_ready,
    input  logic                 i_a_req,
    input  logic                 i_a_wr_en,
    input  logic [ADDR_BITS-1:0] i_a_addr,
    input  logic [WIDTH-1:0]     i_a_data,
    output logic [WIDTH-1:0]     o_a_q,
    output logic                 o_a_valid,
    output logic                 o_a_err,
    input  logic                 i_b_req,
    input  logic [ADDR_BITS-1:0] i_b_addr,
    output logic [WIDTH-1:0]     o_b_q,
    output logic                 o_b_valid
);

    localparam logic [ADDR_BITS:0]   DEPTH_W   = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e                 r_state;
    logic [ADDR_BITS-1:0]   r_clr_cnt;
    logic                   r_ready;

    logic [WIDTH-1:0]       r_mem [DEPTH];

    logic                   w_a_acc, w_a_wr, w_a_rd, w_a_oor, w_a_wr_ok;
    logic                   w_b_rd, w_b_oor;
    logic [WIDTH-1:0]       w_a_rdata, w_b_rdata;

    // Final pipeline stage feeding the output registers.
    logic                   w_a_fin_v, w_a_fin_e, w_b_fin_v;
    logic [WIDTH-1:0]       w_a_fin_d, w_b_fin_d;

    logic                   r_a_valid, r_a_err, r_b_valid;
    logic [WIDTH-1:0]       r_a_q, r_b_q;

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_a_acc   = i_a_req & r_ready;
        w_a_oor   = ({1'b0, i_a_addr} >= DEPTH_W);
        w_a_wr    = w_a_acc & i_a_wr_en;
        w_a_rd    = w_a_acc & ~i_a_wr_en;
        w_a_wr_ok = w_a_wr & ~w_a_oor;
        w_b_rd    = i_b_req & r_ready;
        w_b_oor   = ({1'b0, i_b_addr} >= DEPTH_W);
    end

    // Read data at acceptance. Port B is write-first against a same-cycle
    // port A write, so the incoming word is forwarded around the array.
    always_comb begin
        w_a_rdata = '0;
        if (!w_a_oor) begin
            w_a_rdata = r_mem[i_a_addr];
        end
        w_b_rdata = '0;
        if (!w_b_oor) begin
            if (w_a_wr_ok && (i_a_addr == i_b_addr)) begin
                w_b_rdata = i_a_data;
            end else begin
                w_b_rdata = r_mem[i_b_addr];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage array; not reset, the clear sequence initialises it
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (r_state == StClear) begin
            r_mem[r_clr_cnt] <= INIT_VAL;
        end else if (w_a_wr_ok) begin
            r_mem[i_a_addr] <= i_a_data;
        end
    end

    // ---------------------------------------------------------------------
    // Clear / run control
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state   <= StClear;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            unique case (r_state)
                StClear: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state <= StRun;
                        r_ready <= 1'b1;
                    end
                end
                StRun: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= StClear;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Optional extra read stage
    // ---------------------------------------------------------------------
    if (RD_LAT == 2) begin : g_lat2
        logic             r_a_p_v, r_a_p_e, r_b_p_v;
        logic [WIDTH-1:0] r_a_p_d, r_b_p_d;

        always_ff @(posedge i_clock or negedge i_resetn) begin
            if (!i_resetn) begin
                r_a_p_v <= 1'b0;
                r_a_p_e <= 1'b0;
                r_a_p_d <= '0;
                r_b_p_v <= 1'b0;
                r_b_p_d <= '0;
            end else begin
                r_a_p_v <= w_a_rd;
                r_a_p_e <= w_a_rd & w_a_oor;
                r_b_p_v <= w_b_rd;
                if (w_a_rd) begin
                    r_a_p_d <= w_a_rdata;
                end
                if (w_b_rd) begin
                    r_b_p_d <= w_b_rdata;
                end
            end
        end

        assign w_a_fin_v = r_a_p_v;
        assign w_a_fin_e = r_a_p_e;
        assign w_a_fin_d = r_a_p_d;
        assign w_b_fin_v = r_b_p_v;
        assign w_b_fin_d = r_b_p_d;
    end else begin : g_lat1
        assign w_a_fin_v = w_a_rd;
        assign w_a_fin_e = w_a_rd & w_a_oor;
        assign w_a_fin_d = w_a_rdata;
        assign w_b_fin_v = w_b_rd;
        assign w_b_fin_d = w_b_rdata;
    end

    // ---------------------------------------------------------------------
    // Output registers. q only updates with valid so it holds otherwise.
    // Write range errors bypass the read pipeline and report next edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_a_valid <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_q     <= '0;
            r_b_valid <= 1'b0;
            r_b_q     <= '0;
        end else begin
            r_a_valid <= w_a_fin_v;
            r_a_err   <= w_a_fin_e | (w_a_wr & w_a_oor);
            r_b_valid <= w_b_fin_v;
            if (w_a_fin_v) begin
                r_a_q <= w_a_fin_d;
            end
            if (w_b_fin_v) begin
                r_b_q <= w_b_fin_d;
            end
        end
    end

    assign o_ready   = r_ready;
    assign o_a_q     = r_a_q;
    assign o_a_valid = r_a_valid;
    assign o_a_err   = r_a_err;
    assign o_b_q     = r_b_q;
    assign o_b_valid = r_b_valid;

endmodule

// File: tb/tb_mem_block_dp.sv
// ---------------------------------------------------------------------------
// tb_mem_block_dp
// Directed bench for mem_block_dp. Three instances share one stimulus:
//   p : DEPTH=32, RD_LAT=1    l : DEPTH=32, RD_LAT=2    d : DEPTH=24, RD_LAT=1
// ---------------------------------------------------------------------------
module tb_mem_block_dp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0;
    logic        a_wr = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [15:0] a_data = '0;
    logic        b_req = 1'b0;
    logic [4:0]  b_addr = '0;

    logic        p_rdy, p_av, p_ae, p_bv;
    logic [15:0] p_aq, p_bq;
    logic        l_rdy, l_av, l_ae, l_bv;
    logic [15:0] l_aq, l_bq;
    logic        d_rdy, d_av, d_ae, d_bv;
    logic [15:0] d_aq, d_bq;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_block_dp #(.ADDR_BITS(5), .WIDTH(16), .DEPTH(32), .RD_LAT(1), .INIT_VAL(16'h0000)) u_p (
        .i_clock(clk), .i_resetn(rst_n), .o_ready(p_rdy),
        .i_a_req(a_req), .i_a_wr_en(a_wr), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_q(p_aq), .o_a_valid(p_av), .o_a_err(p_ae),
        .i_b_req(b_req), .i_b_addr(b_addr), .o_b_q(p_bq), .o_b_valid(p_bv)
    );

    mem_block_dp #(.ADDR_BITS(5), .WIDTH(16), .DEPTH(32), .RD_LAT(2), .INIT_VAL(16'h0000)) u_l (
        .i_clock(clk), .i_resetn(rst_n), .o_ready(l_rdy),
        .i_a_req(a_req), .i_a_wr_en(a_wr), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_q(l_aq), .o_a_valid(l_av), .o_a_err(l_ae),
        .i_b_req(b_req), .i_b_addr(b_addr), .o_b_q(l_bq), .o_b_valid(l_bv)
    );

    mem_block_dp #(.ADDR_BITS(5), .WIDTH(16), .DEPTH(24), .RD_LAT(1), .INIT_VAL(16'h0000)) u_d (
        .i_clock(clk), .i_resetn(rst_n), .o_ready(d_rdy),
        .i_a_req(a_req), .i_a_wr_en(a_wr), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_q(d_aq), .o_a_valid(d_av), .o_a_err(d_ae),
        .i_b_req(b_req), .i_b_addr(b_addr), .o_b_q(d_bq), .o_b_valid(d_bv)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 1'b0;
        a_wr  = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic drive_a(input logic wr, input logic [4:0] addr, input logic [15:0] data);
        a_req  = 1'b1;
        a_wr   = wr;
        a_addr = addr;
        a_data = data;
    endtask

    task automatic drive_b(input logic [4:0] addr);
        b_req  = 1'b1;
        b_addr = addr;
    endtask

    // Runs the clear sequence with requests hammering both ports for the first
    // 20 cycles; checks the edge at which each ready rises and that nothing
    // pulses before then.
    task automatic wait_clear(input int exp_long, input int exp_short, input string tag);
        int rise_p = -1;
        int rise_l = -1;
        int rise_d = -1;
        logic spur = 1'b0;
        drive_a(1'b1, 5'h03, 16'hAAAA);
        drive_b(5'h03);
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 20) idle();
            spur = spur | p_av | p_ae | p_bv | l_av | l_ae | l_bv | d_av | d_ae | d_bv;
            if (rise_p < 0 && p_rdy) rise_p = k;
            if (rise_l < 0 && l_rdy) rise_l = k;
            if (rise_d < 0 && d_rdy) rise_d = k;
            if (rise_p >= 0 && rise_l >= 0 && rise_d >= 0) break;
        end
        idle();
        n_chk++;
        if (rise_p !== exp_long) $display("FAIL %s_rise_p: got %0d want %0d", tag, rise_p, exp_long);
        else n_pass++;
        n_chk++;
        if (rise_l !== exp_long) $display("FAIL %s_rise_l: got %0d want %0d", tag, rise_l, exp_long);
        else n_pass++;
        n_chk++;
        if (rise_d !== exp_short) $display("FAIL %s_rise_d: got %0d want %0d", tag, rise_d, exp_short);
        else n_pass++;
        n_chk++;
        if (spur !== 1'b0) $display("FAIL %s_quiet: got %b want 0", tag, spur);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_chk++;
        if ({p_rdy, p_av, p_ae, p_bv, p_aq, p_bq} !== 36'h0)
            $display("FAIL reset_p: got %h want %h", {p_rdy, p_av, p_ae, p_bv, p_aq, p_bq}, 36'h0);
        else n_pass++;
        n_chk++;
        if ({l_rdy, l_av, l_ae, l_bv, l_aq, l_bq} !== 36'h0)
            $display("FAIL reset_l: got %h want %h", {l_rdy, l_av, l_ae, l_bv, l_aq, l_bq}, 36'h0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(32, 24, "clr0");
    endtask

    // Reads of 5'h1F (A) and 5'h03 (B, targeted by ignored writes during clear).
    task automatic test_init_read();
        drive_a(1'b0, 5'h1F, 16'h0);
        drive_b(5'h03);
        tick();
        idle();
        n_chk++;
        if ({p_av, p_ae, p_aq, p_bv, p_bq} !== {1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000})
            $display("FAIL init_rd_p: got %h want %h", {p_av, p_ae, p_aq, p_bv, p_bq},
                     {1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000});
        else n_pass++;
        n_chk++;
        if ({l_av, l_bv} !== 2'b00) $display("FAIL init_rd_l_early: got %b want 00", {l_av, l_bv});
        else n_pass++;
        n_chk++;
        if ({d_av, d_ae, d_aq, d_bv, d_bq} !== {1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000})
            $display("FAIL init_rd_d: got %h want %h", {d_av, d_ae, d_aq, d_bv, d_bq},
                     {1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000});
        else n_pass++;
        tick();
        n_chk++;
        if ({l_av, l_ae, l_aq, l_bv, l_bq} !== {1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000})
            $display("FAIL init_rd_l: got %h want %h", {l_av, l_ae, l_aq, l_bv, l_bq},
                     {1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000});
        else n_pass++;
        n_chk++;
        if ({p_av, p_bv, d_ae} !== 3'b000) $display("FAIL init_rd_pulse: got %b want 000", {p_av, p_bv, d_ae});
        else n_pass++;
    endtask

    task automatic test_write_read();
        drive_a(1'b1, 5'h00, 16'hF000);
        tick();
        n_chk++;
        if ({p_av, p_ae, p_aq} !== {1'b0, 1'b0, 16'h0000})
            $display("FAIL wr_no_valid: got %h want %h", {p_av, p_ae, p_aq}, {1'b0, 1'b0, 16'h0000});
        else n_pass++;
        drive_a(1'b0, 5'h00, 16'h0);
        drive_b(5'h00);
        tick();
        idle();
        n_chk++;
        if ({p_av, p_aq, p_bv, p_bq} !== {1'b1, 16'hF000, 1'b1, 16'hF000})
            $display("FAIL wr_rd_p: got %h want %h", {p_av, p_aq, p_bv, p_bq}, {1'b1, 16'hF000, 1'b1, 16'hF000});
        else n_pass++;
        n_chk++;
        if ({l_av, l_bv} !== 2'b00) $display("FAIL wr_rd_l_early: got %b want 00", {l_av, l_bv});
        else n_pass++;
        tick();
        n_chk++;
        if ({l_av, l_aq, l_bv, l_bq} !== {1'b1, 16'hF000, 1'b1, 16'hF000})
            $display("FAIL wr_rd_l: got %h want %h", {l_av, l_aq, l_bv, l_bq}, {1'b1, 16'hF000, 1'b1, 16'hF000});
        else n_pass++;
        n_chk++;
        if ({p_av, p_bv, p_aq} !== {1'b0, 1'b0, 16'hF000})
            $display("FAIL q_hold_p: got %h want %h", {p_av, p_bv, p_aq}, {1'b0, 1'b0, 16'hF000});
        else n_pass++;
    endtask

    task automatic test_collision();
        drive_a(1'b1, 5'h07, 16'h1234);
        drive_b(5'h07);
        tick();
        idle();
        n_chk++;
        if ({p_bv, p_bq} !== {1'b1, 16'h1234})
            $display("FAIL coll_p: got %h want %h", {p_bv, p_bq}, {1'b1, 16'h1234});
        else n_pass++;
        tick();
        n_chk++;
        if ({l_bv, l_bq, p_bv} !== {1'b1, 16'h1234, 1'b0})
            $display("FAIL coll_l: got %h want %h", {l_bv, l_bq, p_bv}, {1'b1, 16'h1234, 1'b0});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive_a(1'b0, 5'h00, 16'h0);
        drive_b(5'h07);
        tick();
        n_chk++;
        if ({p_av, p_aq, p_bv, p_bq} !== {1'b1, 16'hF000, 1'b1, 16'h1234})
            $display("FAIL b2b_p0: got %h want %h", {p_av, p_aq, p_bv, p_bq}, {1'b1, 16'hF000, 1'b1, 16'h1234});
        else n_pass++;
        drive_a(1'b0, 5'h07, 16'h0);
        drive_b(5'h00);
        tick();
        idle();
        n_chk++;
        if ({p_av, p_aq, p_bv, p_bq} !== {1'b1, 16'h1234, 1'b1, 16'hF000})
            $display("FAIL b2b_p1: got %h want %h", {p_av, p_aq, p_bv, p_bq}, {1'b1, 16'h1234, 1'b1, 16'hF000});
        else n_pass++;
        n_chk++;
        if ({l_av, l_aq, l_bv, l_bq} !== {1'b1, 16'hF000, 1'b1, 16'h1234})
            $display("FAIL b2b_l0: got %h want %h", {l_av, l_aq, l_bv, l_bq}, {1'b1, 16'hF000, 1'b1, 16'h1234});
        else n_pass++;
        tick();
        n_chk++;
        if ({l_av, l_aq, l_bv, l_bq} !== {1'b1, 16'h1234, 1'b1, 16'hF000})
            $display("FAIL b2b_l1: got %h want %h", {l_av, l_aq, l_bv, l_bq}, {1'b1, 16'h1234, 1'b1, 16'hF000});
        else n_pass++;
    endtask

    // 5'h1A is out of range only for the 24-deep instance.
    task automatic test_out_of_range();
        drive_a(1'b1, 5'h1A, 16'hBEEF);
        tick();
        n_chk++;
        if ({d_av, d_ae, p_ae} !== 3'b010) $display("FAIL oor_wr_err: got %b want 010", {d_av, d_ae, p_ae});
        else n_pass++;
        drive_a(1'b0, 5'h1A, 16'h0);
        drive_b(5'h1A);
        tick();
        idle();
        n_chk++;
        if ({d_av, d_ae, d_aq, d_bv, d_bq} !== {1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000})
            $display("FAIL oor_rd_d: got %h want %h", {d_av, d_ae, d_aq, d_bv, d_bq},
                     {1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000});
        else n_pass++;
        n_chk++;
        if ({p_av, p_ae, p_aq, p_bq} !== {1'b1, 1'b0, 16'hBEEF, 16'hBEEF})
            $display("FAIL inrange_rd_p: got %h want %h", {p_av, p_ae, p_aq, p_bq}, {1'b1, 1'b0, 16'hBEEF, 16'hBEEF});
        else n_pass++;
        tick();
        n_chk++;
        if ({d_ae, l_av, l_ae, l_aq} !== {1'b0, 1'b1, 1'b0, 16'hBEEF})
            $display("FAIL oor_tail: got %h want %h", {d_ae, l_av, l_ae, l_aq}, {1'b0, 1'b1, 1'b0, 16'hBEEF});
        else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({p_rdy, p_aq, p_bq} !== 33'h0) $display("FAIL mid_clr_drop: got %h want 0", {p_rdy, p_aq, p_bq});
        else n_pass++;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(32, 24, "clr1");
        // Location 0 held F000 before the resets; the clear must wipe it.
        drive_a(1'b0, 5'h00, 16'h0);
        tick();
        idle();
        n_chk++;
        if ({p_av, p_aq} !== {1'b1, 16'h0000})
            $display("FAIL cleared_rd: got %h want %h", {p_av, p_aq}, {1'b1, 16'h0000});
        else n_pass++;
    endtask

    // Short reset pulse between edges while the RD_LAT=2 pipeline is loaded.
    task automatic test_reset_inflight();
        drive_a(1'b1, 5'h02, 16'h5555);
        tick();
        drive_a(1'b0, 5'h02, 16'h0);
        drive_b(5'h02);
        tick();
        idle();
        n_chk++;
        if ({p_av, p_aq} !== {1'b1, 16'h5555})
            $display("FAIL inflight_pre: got %h want %h", {p_av, p_aq}, {1'b1, 16'h5555});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({p_rdy, p_av, p_bv, p_aq, p_bq, l_rdy, l_av, l_bv, l_aq, l_bq} !== 70'h0)
            $display("FAIL inflight_drop: got %h want 0",
                     {p_rdy, p_av, p_bv, p_aq, p_bq, l_rdy, l_av, l_bv, l_aq, l_bq});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(32, 24, "clr2");
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_clear();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
